// File: rtl/project_border_writer.sv
// project_border_writer: projects each capture frame onto both axes and writes run borders; `PROJECT_ONESHOT_EN freezes after the first result
module project_border_writer #(
  parameter int NUM_ROW = 1,
  parameter int NUM_COL = 3,
  parameter int H_PIXEL = 480,
  parameter int V_PIXEL = 272,
  parameter int MIN_W   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        monoc,
  input  logic [10:0] xpos,
  input  logic [10:0] ypos,
  output logic        row_border_we,
  output logic [10:0] row_border_addr,
  output logic [10:0] row_border_wdata,
  output logic        col_border_we,
  output logic [10:0] col_border_addr,
  output logic [10:0] col_border_wdata,
  output logic [3:0]  num_row,
  output logic [3:0]  num_col,
  output logic [1:0]  frame_cnt,
  output logic        project_done_flag
);
  localparam int XW = $clog2(H_PIXEL);
  typedef enum logic [1:0] {IDLE, CAPTURE, SCAN, DONE} state_t;
  state_t state, state_n;
  logic [H_PIXEL-1:0] col_flag;
  logic [XW-1:0] sx, xi;
  logic [10:0] row_start, col_start, row_end, col_end;
  logic [3:0] row_cnt, col_cnt, col_cnt_n;
  logic line_fg, row_open, col_open;
  logic valid, sof, eol, eof, start, cap, fg, scan, col_f, col_last;
  logic row_open_ev, row_close_ev, row_keep, row_we_n;
  logic col_open_ev, col_close_ev, col_keep, col_we_n;
  assign valid = xpos < 11'(H_PIXEL) && ypos < 11'(V_PIXEL);
  assign sof = valid && xpos == 11'd0 && ypos == 11'd0;
  assign eol = valid && xpos == 11'(H_PIXEL - 1);
  assign eof = eol && ypos == 11'(V_PIXEL - 1);
`ifdef PROJECT_ONESHOT_EN
  assign start = sof && frame_cnt == 2'd0 && state == IDLE;
`else
  assign start = sof && frame_cnt == 2'd0 && (state == IDLE || state == DONE);
`endif
  assign cap = valid && (state == CAPTURE || start);
  assign fg = (xpos != 11'd0 && line_fg) || !monoc;
  assign row_open_ev = cap && eol && fg && !row_open && row_cnt < 4'(NUM_ROW);
  assign row_close_ev = cap && eol && row_open && (!fg || eof);
  assign row_end = fg ? ypos : ypos - 11'd1;
  assign row_keep = row_end - row_start + 11'd1 >= 11'(MIN_W);
  assign row_we_n = row_open_ev || (row_close_ev && row_keep);
  assign xi = xpos[XW-1:0];
  assign scan = state == SCAN;
  assign col_f = col_flag[sx];
  assign col_last = sx == XW'(H_PIXEL - 1);
  assign col_open_ev = scan && col_f && !col_open && col_cnt < 4'(NUM_COL);
  assign col_close_ev = scan && col_open && (!col_f || col_last);
  assign col_end = col_f ? 11'(sx) : 11'(sx) - 11'd1;
  assign col_keep = col_end - col_start + 11'd1 >= 11'(MIN_W);
  assign col_we_n = col_open_ev || (col_close_ev && col_keep);
  assign col_cnt_n = col_cnt + 4'(col_close_ev && col_keep);
  always_comb begin
    state_n = start ? CAPTURE : (state == CAPTURE && eof) ? SCAN : (scan && col_last) ? DONE : state;
  end
  always_ff @(posedge clk) begin
    if (cap) col_flag[xi] <= !monoc || (ypos != 11'd0 && col_flag[xi]);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      frame_cnt         <= '0;
      row_border_we     <= 1'b0;
      row_border_addr   <= '0;
      row_border_wdata  <= '0;
      col_border_we     <= 1'b0;
      col_border_addr   <= '0;
      col_border_wdata  <= '0;
      num_row           <= '0;
      num_col           <= '0;
      project_done_flag <= 1'b0;
      line_fg           <= 1'b0;
      row_open          <= 1'b0;
      col_open          <= 1'b0;
      row_cnt           <= '0;
      col_cnt           <= '0;
      row_start         <= '0;
      col_start         <= '0;
      sx                <= '0;
    end else begin
      state         <= state_n;
      frame_cnt     <= frame_cnt + 2'(eof);
      line_fg       <= fg;
      row_border_we <= row_we_n;
      col_border_we <= col_we_n;
      if (row_we_n) begin
        row_border_addr  <= {6'd0, row_cnt, row_close_ev};
        row_border_wdata <= row_close_ev ? row_end : ypos;
      end
      if (col_we_n) begin
        col_border_addr  <= {6'd0, col_cnt, col_close_ev};
        col_border_wdata <= col_close_ev ? col_end : 11'(sx);
      end
      row_open <= !start && (row_open_ev || (row_open && !row_close_ev));
      col_open <= !start && (col_open_ev || (col_open && !col_close_ev));
      row_cnt  <= start ? 4'd0 : row_cnt + 4'(row_close_ev && row_keep);
      col_cnt  <= start ? 4'd0 : col_cnt_n;
      if (row_open_ev) row_start <= ypos;
      if (col_open_ev) col_start <= 11'(sx);
      sx <= (scan && !col_last) ? sx + XW'(1) : '0;
      if (start) project_done_flag <= 1'b0;
      else if (scan && col_last) begin
        project_done_flag <= 1'b1;
        num_row           <= row_cnt;
        num_col           <= col_cnt_n;
      end
    end
  end
endmodule
